// File: rtl/wide_add_pkg.sv
// Shared types and constants for the multi-precision add sequencer.
package wide_add_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned DEF_ADD_LAT = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } seq_state_e;

endpackage

// File: rtl/seq_wait_counter.sv
// Loadable down-counter that flags the cycle in which the adder result is due.
module seq_wait_counter
    import wide_add_pkg::*;
#(
    parameter int unsigned ADD_LAT = DEF_ADD_LAT
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);

    localparam int unsigned CNT_W = $clog2(ADD_LAT + 1);

    logic [CNT_W-1:0] cnt_q;

    // Load with the adder latency on issue, count down while waiting, stop at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= CNT_W'(ADD_LAT);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Count of one marks the cycle the adder output belongs to the last issued slice.
    assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-precision add controller: feeds a wide request through a shared pipelined
// 8-bit adder one byte slice at a time, LSB first, rippling carry between slices.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int unsigned WORDS   = 4,
    parameter int unsigned ADD_LAT = DEF_ADD_LAT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORDS*BYTE_W-1:0]   in_a,
    input  logic [WORDS*BYTE_W-1:0]   in_b,
    input  logic                      in_cin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORDS*BYTE_W-1:0]   out_sum,
    output logic                      out_cout,
    output logic [BYTE_W-1:0]         add_a,
    output logic [BYTE_W-1:0]         add_b,
    output logic                      add_cin,
    output logic                      add_issue,
    input  logic [BYTE_W-1:0]         add_sum,
    input  logic                      add_cout
);

    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    seq_state_e                   state_q;
    logic [IDX_W-1:0]             idx_q;
    logic [WORDS-1:0]             byte_en_q;
    logic [WORDS-1:0][BYTE_W-1:0] a_q;
    logic [WORDS-1:0][BYTE_W-1:0] b_q;
    logic [WORDS-1:0][BYTE_W-1:0] sum_q;
    logic                         carry_q;

    logic                         in_ready_q;
    logic                         out_valid_q;
    logic                         out_cout_q;
    logic                         add_issue_q;
    logic                         add_cin_q;
    logic [BYTE_W-1:0]            add_a_q;
    logic [BYTE_W-1:0]            add_b_q;

    logic [IDX_W-1:0]             idx_nxt;
    logic [BYTE_W-1:0]            a_nxt;
    logic [BYTE_W-1:0]            b_nxt;
    logic                         cnt_load;
    logic                         cnt_en;
    logic                         wait_done;

    // Byte mux for the next slice; adder inputs are registered so they line up with ISSUE.
    always_comb begin
        idx_nxt  = idx_q + 1'b1;
        a_nxt    = a_q[idx_nxt];
        b_nxt    = b_q[idx_nxt];
        cnt_load = (state_q == ISSUE);
        cnt_en   = (state_q == WAIT);
    end

    seq_wait_counter #(
        .ADD_LAT (ADD_LAT)
    ) u_wait_cnt (
        .clk    (clk),
        .reset  (reset),
        .load_i (cnt_load),
        .en_i   (cnt_en),
        .done_o (wait_done)
    );

    // Sequencer FSM with all handshake and adder-facing outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            byte_en_q   <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_cout_q  <= 1'b0;
            add_issue_q <= 1'b0;
            add_cin_q   <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q         <= in_a;
                        b_q         <= in_b;
                        carry_q     <= in_cin;
                        idx_q       <= '0;
                        byte_en_q   <= WORDS'(1);
                        in_ready_q  <= 1'b0;
                        // Slice 0 goes straight out so ISSUE sees it this coming cycle.
                        add_issue_q <= 1'b1;
                        add_a_q     <= in_a[BYTE_W-1:0];
                        add_b_q     <= in_b[BYTE_W-1:0];
                        add_cin_q   <= in_cin;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    add_issue_q <= 1'b0;
                    add_a_q     <= '0;
                    add_b_q     <= '0;
                    add_cin_q   <= 1'b0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    if (wait_done) begin
                        for (int i = 0; i < WORDS; i++) begin
                            if (byte_en_q[i]) begin
                                sum_q[i] <= add_sum;
                            end
                        end
                        carry_q   <= add_cout;
                        byte_en_q <= byte_en_q << 1;
                        if (idx_q == LAST_IDX) begin
                            out_valid_q <= 1'b1;
                            out_cout_q  <= add_cout;
                            state_q     <= DONE;
                        end else begin
                            idx_q       <= idx_nxt;
                            add_issue_q <= 1'b1;
                            add_a_q     <= a_nxt;
                            add_b_q     <= b_nxt;
                            add_cin_q   <= add_cout;
                            state_q     <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_cout_q  <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = out_cout_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign add_issue = add_issue_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed and randomised bench for wide_add_sequencer with a 2-stage adder model.
module tb_wide_add_sequencer;

    localparam int NREQ = 400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // 32-bit instance
    logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout;
    logic [31:0] in_a, in_b, out_sum;
    logic [7:0]  add_a, add_b, add_sum;
    logic        add_cin, add_issue, add_cout;
    logic [8:0]  p0_q, p1_q;

    // 8-bit instance
    logic        in_valid1, in_ready1, in_cin1, out_valid1, out_ready1, out_cout1;
    logic [7:0]  in_a1, in_b1, out_sum1;
    logic [7:0]  add_a1, add_b1, add_sum1;
    logic        add_cin1, add_issue1, add_cout1;
    logic [8:0]  q0_q, q1_q;

    wide_add_sequencer #(.WORDS(4), .ADD_LAT(2)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_issue(add_issue),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    wide_add_sequencer #(.WORDS(1), .ADD_LAT(2)) u_dut1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1),
        .in_cin(in_cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_sum(out_sum1), .out_cout(out_cout1),
        .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1), .add_issue(add_issue1),
        .add_sum(add_sum1), .add_cout(add_cout1)
    );

    // Adder model: result of inputs applied in cycle t appears in cycle t+2; flushed by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            p0_q <= '0;
            p1_q <= '0;
            q0_q <= '0;
            q1_q <= '0;
        end else begin
            p0_q <= {1'b0, add_a} + {1'b0, add_b} + 9'(add_cin);
            p1_q <= p0_q;
            q0_q <= {1'b0, add_a1} + {1'b0, add_b1} + 9'(add_cin1);
            q1_q <= q0_q;
        end
    end
    assign {add_cout, add_sum}   = p1_q;
    assign {add_cout1, add_sum1} = q1_q;

    int n_tests = 0;
    int n_fail  = 0;
    int issue_cin[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request in the current cycle; returns in cycle 1 after the handshake.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        chk("send_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    // Count cycles from handshake until out_valid, recording carry-in of every issued slice.
    task automatic wait_out(output int lat);
        lat = 1;
        issue_cin.delete();
        while (!out_valid && lat < 200) begin
            if (add_issue) issue_cin.push_back(int'(add_cin));
            step();
            lat++;
        end
    endtask

    task automatic take(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        chk({tag, "_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int          lat;
        int          t;
        int          acc_t[$];
        int          diff;
        int          n_acc;
        int          n_take;
        int          guard;
        logic [32:0] expq[$];
        logic [32:0] e;

        reset = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
        in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_cin1 = 1'b0; out_ready1 = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_add_issue", 64'(add_issue), 64'd0);
        chk("rst_add_a", 64'(add_a), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_out_cout", 64'(out_cout), 64'd0);
        chk("rst_in_ready1", 64'(in_ready1), 64'd1);
        reset = 1'b0;
        step();

        // 1: full carry ripple
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        wait_out(lat);
        chk("t1_latency", 64'(lat), 64'd13);
        chk("t1_sum", 64'(out_sum), 64'h0000_0000);
        chk("t1_cout", 64'(out_cout), 64'd1);
        chk("t1_in_ready_busy", 64'(in_ready), 64'd0);
        take("t1");

        // 2: carry-in only, upper slices must see add_cin=0
        send(32'h0, 32'h0, 1'b1);
        wait_out(lat);
        chk("t2_latency", 64'(lat), 64'd13);
        chk("t2_sum", 64'(out_sum), 64'h0000_0001);
        chk("t2_cout", 64'(out_cout), 64'd0);
        chk("t2_issues", 64'(issue_cin.size()), 64'd4);
        if (issue_cin.size() == 4) begin
            chk("t2_cin_slice0", 64'(issue_cin[0]), 64'd1);
            for (int i = 1; i < 4; i++) chk("t2_cin_upper", 64'(issue_cin[i]), 64'd0);
        end
        take("t2");

        // 3: back-pressure holds result, new requests ignored
        send(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        wait_out(lat);
        chk("t3_latency", 64'(lat), 64'd13);
        in_a = 32'hDEAD_BEEF; in_b = 32'h1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("t3_hold_valid", 64'(out_valid), 64'd1);
            chk("t3_hold_sum", 64'(out_sum), 64'hACF1_3568);
            chk("t3_hold_cout", 64'(out_cout), 64'd0);
            chk("t3_hold_in_ready", 64'(in_ready), 64'd0);
            step();
        end
        in_valid = 1'b0;
        take("t3");

        // 4: reset during WAIT of slice 2
        send(32'h1111_1111, 32'h2222_2222, 1'b0);
        repeat (6) step();
        chk("t4_slice2_issue", 64'(add_issue), 64'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t4_abort_valid", 64'(out_valid), 64'd0);
        chk("t4_abort_ready", 64'(in_ready), 64'd1);
        chk("t4_abort_sum", 64'(out_sum), 64'd0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_out(lat);
        chk("t4_latency", 64'(lat), 64'd13);
        chk("t4_sum", 64'(out_sum), 64'd0);
        chk("t4_cout", 64'(out_cout), 64'd1);
        take("t4");

        // 6: single-slice instance
        in_a1 = 8'hFF; in_b1 = 8'h01; in_cin1 = 1'b1; in_valid1 = 1'b1;
        chk("t6_in_ready", 64'(in_ready1), 64'd1);
        step();
        in_valid1 = 1'b0;
        lat = 1;
        while (!out_valid1 && lat < 50) begin
            step();
            lat++;
        end
        chk("t6_latency", 64'(lat), 64'd4);
        chk("t6_sum", 64'(out_sum1), 64'h01);
        chk("t6_cout", 64'(out_cout1), 64'd1);
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;
        chk("t6_valid_drop", 64'(out_valid1), 64'd0);

        // 7: throughput with continuous valid/ready
        out_ready = 1'b1; in_valid = 1'b1; in_a = 32'h5; in_b = 32'h7; in_cin = 1'b0;
        t = 0;
        while (acc_t.size() < 2 && t < 100) begin
            if (in_ready) acc_t.push_back(t);
            step();
            t++;
        end
        in_valid = 1'b0;
        diff = (acc_t.size() == 2) ? (acc_t[1] - acc_t[0]) : -1;
        chk("t7_throughput", 64'(diff), 64'd14);
        repeat (20) step();
        out_ready = 1'b0;
        chk("t7_drained", 64'(in_ready), 64'd1);

        // 5: random traffic against a queue of golden sums
        n_acc = 0; n_take = 0; guard = 0;
        while (n_take < NREQ && guard < 40000) begin
            in_a      = $urandom;
            in_b      = $urandom;
            in_cin    = 1'($urandom_range(0, 1));
            in_valid  = (n_acc < NREQ) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) begin
                expq.push_back({1'b0, in_a} + {1'b0, in_b} + 33'(in_cin));
                n_acc++;
            end
            if (out_valid && out_ready) begin
                if (expq.size() > 0) e = expq.pop_front();
                else e = 'x;
                chk("t5_result", 64'({out_cout, out_sum}), 64'(e));
                n_take++;
            end
            step();
            guard++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) step();
        chk("t5_accepted", 64'(n_acc), 64'(NREQ));
        chk("t5_taken", 64'(n_take), 64'(NREQ));
        chk("t5_queue_empty", 64'(expq.size()), 64'd0);
        chk("t5_no_extra", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
